hola: RTL and testbench
=======================

HOLA -- requirements
Module: hola

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the s1-high event counter.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-004 Port a SHALL be an input, 1 bit: logic operand, MSB of the input index {a,b,c,d}.
REQ-005 Port b SHALL be an input, 1 bit: logic operand.
REQ-006 Port c SHALL be an input, 1 bit: logic operand.
REQ-007 Port d SHALL be an input, 1 bit: logic operand, LSB of the input index.
REQ-008 Port clr SHALL be an input, 1 bit: synchronous clear of seen and cnt.
REQ-009 Port s1 SHALL be an output, 1 bit: registered function result.
REQ-010 Port seen SHALL be an output, 16 bits: bit i set once input index i has been sampled.
REQ-011 Port cnt SHALL be an output, CNT_W bits: saturating count of cycles in which the evaluated function was 1.

Function
REQ-012 Fixed function f SHALL be (a AND NOT b) OR (NOT c AND d), built from NOT, AND and OR gate instances.
REQ-013 Truth-table mask SHALL be 0x2F22, where bit i is f for index i={a,b,c,d}; f=1 exactly for indices 1, 5, 8, 9, 10, 11, 13.
REQ-014 s1 SHALL equal f of the a/b/c/d values present at the previous rising clk edge, giving one-cycle latency.
REQ-015 Inputs SHALL be sampled directly with no synchronizers, and all four SHALL be treated as sampled in the same cycle.
REQ-016 Each edge, seen[index] SHALL set to 1; seen bits SHALL be sticky until clr or reset.
REQ-017 Each edge with f=1, cnt SHALL increment by 1; at all-ones cnt SHALL saturate and hold.
REQ-018 When clr=1 at an edge, seen and cnt SHALL load 0, overriding that cycle's update; s1 SHALL still update normally.
REQ-019 X or Z on a/b/c/d is a usage error; no defined s1 value is required.

Reset
REQ-020 While rst_n=0, s1 SHALL be 0, seen SHALL be 0x0000 and cnt SHALL be 0, regardless of clk.
REQ-021 Reset assertion mid-sweep SHALL clear all state immediately.
REQ-022 The first edge after rst_n deasserts SHALL sample inputs normally.

Configuration
REQ-023 Macro HOLA_LUT_EN, when defined, SHALL add input lut_wr (1 bit) and input lut_data (16 bits); an internal 16-bit LUT register SHALL reset to 0x2F22 and load lut_data on edges where lut_wr=1.
REQ-024 With HOLA_LUT_EN defined, f SHALL be LUT[index], and a write SHALL take effect for the sample at the following edge.
REQ-025 Without HOLA_LUT_EN, the LUT ports SHALL be absent and f SHALL be the fixed gate network.

Structure
REQ-026 Shared package hola_pkg SHALL hold the HOLA_MASK=16'h2F22 constant and the index typedef (4 bits).
REQ-027 Sub-module hola_logic SHALL be the purely combinational gate network computing f, instantiated once.

Verification
REQ-028 Exhaustive sweep: indices 0..15, one per cycle -> s1 sequence one cycle later = 0,1,0,0,0,1,0,0,1,1,1,1,0,1,0,0; seen=0xFFFF; cnt=7.
REQ-029 Saturation: CNT_W=3, index 8 held for 10 cycles -> cnt reaches 7 and holds, s1 stays 1.
REQ-030 Clear: after a full sweep, clr=1 for one cycle with index 1 -> next cycle seen=0, cnt=0, s1=1.
REQ-031 Async reset: rst_n pulled low mid-sweep between edges -> s1/seen/cnt go 0 with no clock edge; restart from index 0 is correct.
REQ-032 LUT (HOLA_LUT_EN): write 0x8000 -> only index 15 yields s1=1; sweep gives cnt=1.
REQ-033 Hold: index 3 held 5 cycles -> s1=0, cnt unchanged, seen=0x0008 after reset.

Source files
------------

// File: rtl/hola_pkg.sv
// hola_pkg: shared truth-table constant, input-index type and index decoder
// used by the hola function block.
package hola_pkg;

  localparam logic [15:0] HOLA_MASK = 16'h2F22;

  typedef logic [3:0] index_t;

  function automatic logic [15:0] index_onehot(input index_t idx);
    index_onehot = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/hola_logic.sv
// hola_logic: combinational gate network f = (a & ~b) | (~c & d).
module hola_logic (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic f
);

  logic nb_s;
  logic nc_s;
  logic t0_s;
  logic t1_s;

  not u_nb (nb_s, b);
  not u_nc (nc_s, c);
  and u_t0 (t0_s, a, nb_s);
  and u_t1 (t1_s, nc_s, d);
  or  u_f  (f, t0_s, t1_s);

endmodule

// File: rtl/hola.sv
// hola: registered 4-input function with sticky index-seen map and saturating hit
// counter. Define HOLA_LUT_EN to replace the fixed gates with a writable 16-bit LUT.
module hola
  import hola_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             clr,
`ifdef HOLA_LUT_EN
  input  logic             lut_wr,
  input  logic [15:0]      lut_data,
`endif
  output logic             s1,
  output logic [15:0]      seen,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  index_t           idx_s;
  logic             f_s;
  logic             s1_q, s1_d;
  logic [15:0]      seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign idx_s = {a, b, c, d};

`ifdef HOLA_LUT_EN
  logic [15:0] lut_q, lut_d;

  // A write lands in lut_q, so it governs the sample taken at the following edge.
  always_comb begin
    lut_d = lut_q;
    if (lut_wr) begin
      lut_d = lut_data;
    end else begin
      lut_d = lut_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_q <= HOLA_MASK;
    end else begin
      lut_q <= lut_d;
    end
  end

  assign f_s = lut_q[idx_s];
`else
  hola_logic u_logic (
    .a (a),
    .b (b),
    .c (c),
    .d (d),
    .f (f_s)
  );
`endif

  // clr wipes seen/cnt but leaves s1 tracking the current sample.
  always_comb begin
    s1_d   = f_s;
    seen_d = seen_q;
    cnt_d  = cnt_q;
    if (clr) begin
      seen_d = 16'h0000;
      cnt_d  = CNT_ZERO;
    end else begin
      seen_d = seen_q | index_onehot(idx_s);
      if (f_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      seen_q <= 16'h0000;
      cnt_q  <= CNT_ZERO;
    end else begin
      s1_q   <= s1_d;
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s1   = s1_q;
  assign seen = seen_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_hola.sv
// tb_hola: randomized and directed checks of hola (CNT_W=8 and CNT_W=3 instances
// on shared inputs) against a behavioural model of the function and counters.
module tb_hola;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a, b, c, d, clr;
`ifdef HOLA_LUT_EN
  logic        lut_wr;
  logic [15:0] lut_data;
`endif
  logic        s1_8, s1_3;
  logic [15:0] seen_8, seen_3;
  logic [7:0]  cnt_8;
  logic [2:0]  cnt_3;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic        m_s1;
  logic [15:0] m_seen;
  int          m_cnt8, m_cnt3;
  logic [15:0] m_lut;

  always #5 clk = ~clk;

  hola #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
`ifdef HOLA_LUT_EN
    .lut_wr(lut_wr), .lut_data(lut_data),
`endif
    .s1(s1_8), .seen(seen_8), .cnt(cnt_8)
  );

  hola #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .clr(clr),
`ifdef HOLA_LUT_EN
    .lut_wr(lut_wr), .lut_data(lut_data),
`endif
    .s1(s1_3), .seen(seen_3), .cnt(cnt_3)
  );

  function automatic logic model_f(input logic [3:0] idx);
`ifdef HOLA_LUT_EN
    return m_lut[idx];
`else
    return (idx[3] & ~idx[2]) | (~idx[1] & idx[0]);
`endif
  endfunction

  function automatic logic [44:0] obs_vec();
    return {s1_8, seen_8, cnt_8, s1_3, seen_3, cnt_3};
  endfunction

  function automatic logic [44:0] exp_vec();
    return {m_s1, m_seen, 8'(m_cnt8), m_s1, m_seen, 3'(m_cnt3)};
  endfunction

  task automatic model_clear();
    m_s1   = 1'b0;
    m_seen = 16'h0000;
    m_cnt8 = 0;
    m_cnt3 = 0;
    m_lut  = 16'h2F22;
  endtask

  // Apply one index for one edge and advance the model; returns #1 after the edge.
  task automatic step(input logic [3:0] idx, input logic cl);
    logic f;
    logic wr;
    logic [15:0] wd;
    {a, b, c, d} = idx;
    clr = cl;
    wr = 1'b0;
    wd = 16'h0000;
`ifdef HOLA_LUT_EN
    wr = lut_wr;
    wd = lut_data;
`endif
    @(posedge clk);
    f = model_f(idx);
    m_s1 = f;
    if (cl) begin
      m_seen = 16'h0000;
      m_cnt8 = 0;
      m_cnt3 = 0;
    end else begin
      m_seen[idx] = 1'b1;
      if (f) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt3 = (m_cnt3 < 7) ? m_cnt3 + 1 : 7;
      end
    end
    if (wr) m_lut = wd;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    {a, b, c, d} = 4'($urandom_range(0, 15));
    model_clear();
    #2;
    n_tests++;
    if (obs_vec() !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_no_edge got=%h exp=0", obs_vec());
    end
    repeat (3) begin
      {a, b, c, d} = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
    end
    n_tests++;
    if (obs_vec() !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_with_clk got=%h exp=0", obs_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [15:0] tbl;
    tbl = 16'h2F22;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0);
      n_tests++;
      if (s1_8 !== tbl[i] || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sweep idx=%0d got=%h exp=%h s1_req=%b", i, obs_vec(), exp_vec(), tbl[i]);
      end
    end
    n_tests++;
    if (seen_8 !== 16'hFFFF || cnt_8 !== 8'd7 || cnt_3 !== 3'd7) begin
      n_fail++;
      $display("FAIL sweep_final seen=%h cnt8=%0d cnt3=%0d exp seen=ffff cnt=7", seen_8, cnt_8, cnt_3);
    end
  endtask

  task automatic test_clear();
    step(4'd1, 1'b1);
    n_tests++;
    if (seen_8 !== 16'h0000 || cnt_8 !== 8'd0 || cnt_3 !== 3'd0 || s1_8 !== 1'b1) begin
      n_fail++;
      $display("FAIL clear seen=%h cnt8=%0d cnt3=%0d s1=%b exp 0/0/0/1", seen_8, cnt_8, cnt_3, s1_8);
    end
    clr = 1'b0;
  endtask

  task automatic test_hold();
    apply_reset();
    repeat (5) step(4'd3, 1'b0);
    n_tests++;
    if (s1_8 !== 1'b0 || cnt_8 !== 8'd0 || seen_8 !== 16'h0008 || obs_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL hold s1=%b cnt=%0d seen=%h exp 0/0/0008", s1_8, cnt_8, seen_8);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      step(4'd8, 1'b0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL saturation cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (cnt_3 !== 3'd7 || s1_3 !== 1'b1 || cnt_8 !== 8'd10) begin
      n_fail++;
      $display("FAIL saturation_final cnt3=%0d s1=%b cnt8=%0d exp 7/1/10", cnt_3, s1_3, cnt_8);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 7; i++) step(4'(i), 1'b0);
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (obs_vec() !== 45'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=0", obs_vec());
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0);
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_restart idx=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (cnt_8 !== 8'd7 || seen_8 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL async_restart_final cnt=%0d seen=%h exp 7/ffff", cnt_8, seen_8);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
      n_tests++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    clr = 1'b0;
  endtask

`ifdef HOLA_LUT_EN
  task automatic test_lut();
    apply_reset();
    lut_wr = 1'b1;
    lut_data = 16'h8000;
    step(4'd0, 1'b0);
    lut_wr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(4'(i), 1'b0);
      n_tests++;
      if (s1_8 !== (i == 15) || obs_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL lut idx=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
    n_tests++;
    if (cnt_8 !== 8'd1) begin
      n_fail++;
      $display("FAIL lut_cnt got=%0d exp=1", cnt_8);
    end
  endtask
`endif

  initial begin
`ifdef HOLA_LUT_EN
    lut_wr = 1'b0;
    lut_data = 16'h0000;
`endif
    clr = 1'b0;
    test_reset();
    test_sweep();
    test_clear();
    test_hold();
    test_saturation();
    test_async_reset();
    test_random();
`ifdef HOLA_LUT_EN
    test_lut();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
